// File: rtl/life_controller.sv
// Per-tank life counters with hit cooldown; serialises heart-erase requests
// to the downstream erase stage and flags game over and the winner.
module life_controller #(
  parameter int unsigned INVULN_CYCLES = 50_000_000
) (
  input  logic       iCLOCK_50,
  input  logic       ireset,
  input  logic       iNewGame,
  input  logic       iP1Hit,
  input  logic       iP2Hit,
  input  logic       iEraseDone,
  output logic [1:0] oP1Life,
  output logic [1:0] oP2Life,
  output logic       oEraseP1Heart,
  output logic       oEraseP2Heart,
  output logic       oBusy,
  output logic       oGameOver,
  output logic [1:0] oWinner
);

  localparam int unsigned CNT_W = $clog2(INVULN_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ_P1   = 2'd1,
    ST_REQ_P2   = 2'd2,
    ST_GAMEOVER = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             p1_pend, p2_pend;
  logic [CNT_W-1:0] p1_cd, p2_cd;
  logic             req_p1_q, req_p2_q;
  logic             p1_acc, p2_acc;
  logic             take_p1, take_p2;
  logic             enter_go;

  assign p1_acc = iP1Hit && (state_q != ST_GAMEOVER) && (oP1Life != 2'd0)
                  && (p1_cd == '0) && !p1_pend;
  assign p2_acc = iP2Hit && (state_q != ST_GAMEOVER) && (oP2Life != 2'd0)
                  && (p2_cd == '0) && !p2_pend;

  assign take_p1  = (state_q == ST_IDLE) && (state_d == ST_REQ_P1);
  assign take_p2  = (state_q == ST_IDLE) && (state_d == ST_REQ_P2);
  assign enter_go = (state_q != ST_GAMEOVER) && (state_d == ST_GAMEOVER);

  // State register
  always_ff @(posedge iCLOCK_50 or posedge ireset) begin
    if (ireset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; new game overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (p1_pend)      state_d = ST_REQ_P1;
        else if (p2_pend) state_d = ST_REQ_P2;
      end
      ST_REQ_P1: if (iEraseDone) state_d = (oP1Life == 2'd0) ? ST_GAMEOVER : ST_IDLE;
      ST_REQ_P2: if (iEraseDone) state_d = (oP2Life == 2'd0) ? ST_GAMEOVER : ST_IDLE;
      ST_GAMEOVER: state_d = ST_GAMEOVER;
      default: state_d = ST_IDLE;
    endcase
    if (iNewGame) state_d = ST_IDLE;
  end

  // Request masked in the done cycle so the erase stage does not relaunch
  always_comb begin
    oEraseP1Heart = req_p1_q & ~iEraseDone;
    oEraseP2Heart = req_p2_q & ~iEraseDone;
    oBusy         = (state_q == ST_REQ_P1) || (state_q == ST_REQ_P2);
  end

  // Lives, pending hits, cooldowns, requests and result flags
  always_ff @(posedge iCLOCK_50 or posedge ireset) begin
    if (ireset) begin
      oP1Life   <= 2'b11;
      oP2Life   <= 2'b11;
      p1_pend   <= 1'b0;
      p2_pend   <= 1'b0;
      p1_cd     <= '0;
      p2_cd     <= '0;
      req_p1_q  <= 1'b0;
      req_p2_q  <= 1'b0;
      oGameOver <= 1'b0;
      oWinner   <= 2'b00;
    end else if (iNewGame) begin
      oP1Life   <= 2'b11;
      oP2Life   <= 2'b11;
      p1_pend   <= 1'b0;
      p2_pend   <= 1'b0;
      p1_cd     <= '0;
      p2_cd     <= '0;
      req_p1_q  <= 1'b0;
      req_p2_q  <= 1'b0;
      oGameOver <= 1'b0;
      oWinner   <= 2'b00;
    end else begin
      if (p1_acc)              p1_cd <= CNT_W'(INVULN_CYCLES);
      else if (p1_cd != '0)    p1_cd <= p1_cd - CNT_W'(1);
      if (p2_acc)              p2_cd <= CNT_W'(INVULN_CYCLES);
      else if (p2_cd != '0)    p2_cd <= p2_cd - CNT_W'(1);

      if (state_d == ST_GAMEOVER || take_p1) p1_pend <= 1'b0;
      else if (p1_acc)                       p1_pend <= 1'b1;
      if (state_d == ST_GAMEOVER || take_p2) p2_pend <= 1'b0;
      else if (p2_acc)                       p2_pend <= 1'b1;

      if (take_p1) oP1Life <= oP1Life - 2'd1;
      if (take_p2) oP2Life <= oP2Life - 2'd1;

      req_p1_q <= (state_d == ST_REQ_P1);
      req_p2_q <= (state_d == ST_REQ_P2);

      if (enter_go) begin
        oGameOver <= 1'b1;
        oWinner   <= (state_q == ST_REQ_P1) ? 2'b10 : 2'b01;
      end
    end
  end

endmodule

// File: doc/life_controller.md
# life_controller

Tracks both tanks' remaining lives and turns bullet-hit pulses into heart-erase requests for the heart-erase stage. It sits directly upstream of that stage: it owns the life counters, issues one erase at a time through a request/done handshake, and enforces a post-hit invulnerability window. It declares game over and the winner when a life count reaches zero.

## Interface
- INVULN_CYCLES, 50_000_000 — cycles a player ignores further hits after a hit is accepted (1 s at 50 MHz); counter width = clog2(INVULN_CYCLES+1)
- iCLOCK_50  in  1  system clock, all logic on rising edge
- ireset  in  1  asynchronous, active-high reset
- iNewGame  in  1  single-cycle pulse, restarts the match
- iP1Hit  in  1  single-cycle pulse, P1 tank struck
- iP2Hit  in  1  single-cycle pulse, P2 tank struck
- iEraseDone  in  1  single-cycle done pulse from heart-erase stage
- oP1Life  out  2  P1 lives remaining (3..0)
- oP2Life  out  2  P2 lives remaining (3..0)
- oEraseP1Heart  out  1  erase request for P1's heart selected by oP1Life
- oEraseP2Heart  out  1  erase request for P2's heart selected by oP2Life
- oBusy  out  1  erase in flight (state is ST_REQ_P1 or ST_REQ_P2)
- oGameOver  out  1  match finished
- oWinner  out  2  01 = P1 won, 10 = P2 won, 00 = none

## Operation
- Reset values: oP1Life = oP2Life = 2'b11, all requests 0, oBusy 0, oGameOver 0, oWinner 00, pending flags 0, cooldown counters 0, state ST_IDLE.
- Hit acceptance, per player: a hit pulse is accepted iff the state is not ST_GAMEOVER, the player's life is nonzero, the player's cooldown is 0, and the player's pending flag is 0.
  - Acceptance sets the pending flag and loads the cooldown counter with INVULN_CYCLES on the same edge.
  - Rejected hits are dropped silently.
- Cooldown: decrements by 1 each cycle while nonzero and saturates at 0.
- State machine:
  - ST_IDLE: if P1 pending → ST_REQ_P1; else if P2 pending → ST_REQ_P2. On that edge, the selected life decrements by 1 and its pending flag clears. P1 has priority.
  - ST_REQ_P1 / ST_REQ_P2: the internal request register is 1.
    - oEraseP1Heart = reqP1 & ~iEraseDone; oEraseP2Heart = reqP2 & ~iEraseDone. This combinational mask drops the request during the done cycle so the erase stage does not relaunch.
    - On iEraseDone: if that player's life is now 0 → ST_GAMEOVER; else → ST_IDLE.
    - The life value is held stable for the whole request, because the erase stage decodes the heart position from it.
  - ST_GAMEOVER: oGameOver = 1 and oWinner = the opponent of the player who reached 0. All pending flags clear, and hits are ignored. The block stays here until iNewGame.
- iNewGame, in any state: on that edge, lives return to 3, pending flags, cooldowns and requests clear, oGameOver and oWinner clear, and the state goes to ST_IDLE. An erase already launched downstream completes on its own; its late iEraseDone is ignored in ST_IDLE.
- Simultaneous hits on the same edge: both are accepted independently. P1 is serviced first, then P2 on its return to ST_IDLE.
- P1 reaching 0 while a P2 hit is pending: the pending P2 hit is discarded, and the winner is P2.
- iEraseDone outside the REQ states: ignored.
- Life arithmetic is 2-bit unsigned. A decrement is only performed when life is nonzero, so it never wraps.

## Timing
- Hit pulse at cycle t: pending is set at edge t+1.
- With the state in ST_IDLE, the life decrements and the request rises after edge t+2. Hit-to-request latency is 2 cycles.
- The request stays high until the cycle in which iEraseDone = 1, where it is masked low combinationally. The state leaves REQ at the edge ending that cycle.
- Back-to-back erases: minimum 1 ST_IDLE cycle between consecutive requests.
- oGameOver and oWinner go high 1 cycle after the final iEraseDone.
- ireset asserted mid-request: all outputs go to reset values immediately (asynchronous).

## Test plan
- Reset, then an iP1Hit pulse → oP1Life = 2 and oEraseP1Heart = 1 two cycles later. Pulse iEraseDone → the request drops in the same cycle, the state returns to ST_IDLE, and oBusy = 0.
- INVULN_CYCLES = 8; iP1Hit at t and again at t+3 → only one decrement (life 2). A third hit at t+12 → life 1.
- iP1Hit and iP2Hit on the same edge → P1 request first with oP1Life = 2. After done, oEraseP2Heart asserts with oP2Life = 2. P1's request never overlaps P2's.
- Three accepted P2 hits, each completed with iEraseDone → oP2Life = 0, oGameOver = 1 and oWinner = 01 one cycle after the last done. A further iP1Hit leaves oP1Life unchanged.
- iNewGame pulsed while oEraseP1Heart = 1 → both lives 3, no requests, ST_IDLE. A subsequent stray iEraseDone causes no change.
- ireset asserted mid-request without a clock edge → all outputs are at reset values before the next edge.
